// File: rtl/kf_axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kf_axi_pkg                                                         |
// | AXI encodings, beat/page geometry and write-engine state type.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package kf_axi_pkg;

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int BPB        = 64;
  localparam int BPB_LOG2   = 6;
  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_LOG2  = 12;
  localparam int PAGE_BEATS = PAGE_BYTES / BPB;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4,
    ST_FIN  = 3'd5
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/kf_beat_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kf_beat_fifo                                                       |
// | Synchronous DEPTH x DATA_W beat FIFO with occupancy count.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module kf_beat_fifo #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign count     = r_wptr - r_rptr;
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rptr[PTR_W-1:0]];

  // Storage is not reset: occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kf_axi_wr_burst.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kf_axi_wr_burst                                                    |
// | Buffers result beats and writes them as 4 KB-safe AXI4 INCR bursts.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module kf_axi_wr_burst #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [15:0]           cfg_total_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  import kf_axi_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e         r_state;
  wr_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_rem_aw;
  logic [15:0]       r_rem_in;
  logic [6:0]        r_len;
  logic [7:0]        r_awlen;
  logic [6:0]        r_wcnt;
  logic              r_err;
  logic [6:0]        w_len;
  logic [6:0]        w_page_beats;
  logic              w_busy;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_fill_go;
  logic [CNT_W-1:0]  w_count;

  kf_beat_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (s_data),
    .pop       (w_pop),
    .pop_data  (m_axi_wdata),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign w_busy        = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign busy          = w_busy;
  assign err           = r_err;
  assign s_ready       = w_busy && !w_full && (r_rem_in != 16'd0);
  assign w_push        = s_valid && s_ready;
  assign w_pop         = m_axi_wvalid && m_axi_wready;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = AXI_SIZE_64B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = '1;

  // Beats left before the next 4 KB page boundary, always 1..PAGE_BEATS.
  always_comb begin
    w_page_beats = 7'(PAGE_BEATS) - 7'(r_addr[PAGE_LOG2-1:BPB_LOG2]);
    w_len        = 7'(MAX_BURST);
    if (r_rem_aw < 16'(w_len)) w_len = r_rem_aw[6:0];
    if (w_page_beats < w_len)  w_len = w_page_beats;
  end

  assign w_fill_go = (r_rem_aw != 16'd0) && (16'(w_count) >= 16'(w_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    done          = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_FILL;
      ST_FILL: begin
        if (r_rem_aw == 16'd0) w_next = ST_FIN;
        else if (w_fill_go)    w_next = ST_AW;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_next = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = !w_empty;
        m_axi_wlast  = (r_wcnt == r_len - 7'd1);
        if (m_axi_wvalid && m_axi_wready && m_axi_wlast) w_next = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_next = ST_FILL;
      end
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_rem_aw <= '0;
      r_rem_in <= '0;
      r_len    <= '0;
      r_awlen  <= '0;
      r_wcnt   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_rem_in <= r_rem_in - 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr   <= cfg_base_addr & ~ADDR_W'(BPB - 1);
            r_rem_aw <= cfg_total_beats;
            r_rem_in <= cfg_total_beats;
            r_err    <= 1'b0;
          end
        end
        ST_FILL: begin
          if (w_fill_go) begin
            r_len   <= w_len;
            r_awlen <= 8'(w_len) - 8'd1;
            r_wcnt  <= '0;
          end
        end
        ST_W: if (w_pop) r_wcnt <= r_wcnt + 7'd1;
        ST_B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != AXI_RESP_OKAY) r_err <= 1'b1;
            r_addr   <= r_addr + (ADDR_W'(r_len) << BPB_LOG2);
            r_rem_aw <= r_rem_aw - 16'(r_len);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
